// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - multi-slot BCD alarm controller with ring timeout, dismiss and optional snooze
//
// Purpose: holds N_ALARM alarm slots {tone, hh, mm} (BCD) and compares them on
// every sec_tick against the running BCD time of day. The lowest matching
// enabled slot (tone != 0) starts a ring that stops after RING_SEC ticks, on
// dismiss, or (optionally) moves to a snooze that re-rings SNOOZE_MIN minutes
// later.
//
// Optional feature macro: ALARM_BANK_SNOOZE_EN (snooze state and target logic).
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   sec_tick_i            one-cycle pulse per second, aligned with clock_data_i
//   clock_data_i[23:0]    BCD {hh, mm, ss}
//   wr_en_i/wr_idx_i/wr_data_i   slot write {tone, hh, mm}
//   wr_err_o              one-cycle pulse after a rejected write
//   rd_idx_i/rd_data_o    registered slot readback
//   key_dismiss_i         stop ringing / cancel snooze
//   key_snooze_i          snooze while ringing
//   ring_active_o         high while ringing
//   ring_start_o          one-cycle pulse on each entry into ringing
//   ring_tone_o           tone of ringing slot, 0 when not ringing
//   ring_idx_o            index of the slot that triggered
module alarm_bank #(
  parameter int N_ALARM    = 4,
  parameter int TONE_W     = 2,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  localparam int IDX_W     = (N_ALARM > 1) ? $clog2(N_ALARM) : 1,
  localparam int SLOT_W    = TONE_W + 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sec_tick_i,
  input  logic [23:0]       clock_data_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [SLOT_W-1:0] wr_data_i,
  output logic              wr_err_o,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [SLOT_W-1:0] rd_data_o,
  input  logic              key_dismiss_i,
  input  logic              key_snooze_i,
  output logic              ring_active_o,
  output logic              ring_start_o,
  output logic [TONE_W-1:0] ring_tone_o,
  output logic [IDX_W-1:0]  ring_idx_o
);

  localparam logic [IDX_W:0] N_LIM    = (IDX_W+1)'(N_ALARM);
  localparam logic [7:0]     RING_LIM = 8'(RING_SEC);

`ifdef ALARM_BANK_SNOOZE_EN
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
`else
  typedef enum logic {IDLE, RINGING} state_t;
`endif

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q [N_ALARM];
  logic [SLOT_W-1:0]   rd_data_q;
  logic                wr_err_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TONE_W-1:0]   tone_q, tone_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                start_q, start_d;

  // Write validation: BCD hh <= 23, mm <= 59, each nibble a decimal digit.
  logic [7:0] wr_hh, wr_mm;
  logic       wr_ok;
  assign wr_hh = wr_data_i[15:8];
  assign wr_mm = wr_data_i[7:0];
  assign wr_ok = (wr_hh <= 8'h23) && (wr_hh[3:0] <= 4'd9) &&
                 (wr_mm <= 8'h59) && (wr_mm[3:0] <= 4'd9) &&
                 ({1'b0, wr_idx_i} < N_LIM);

  // Slot match; scanning downward leaves the lowest matching index.
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [TONE_W-1:0] hit_tone;
  logic              match;
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if ((slot_q[i][SLOT_W-1 -: TONE_W] != '0) &&
          (clock_data_i == {slot_q[i][15:0], 8'h00})) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end
  assign hit_tone = slot_q[hit_idx][SLOT_W-1 -: TONE_W];
  assign match    = sec_tick_i && hit;

`ifdef ALARM_BANK_SNOOZE_EN
  logic [15:0] tgt_q, tgt_d;

  // {hh, mm} BCD + SNOOZE_MIN minutes, wrapping 23:59 -> 00:00.
  function automatic logic [15:0] add_snooze(input logic [15:0] hhmm);
    logic [6:0] m;
    logic [4:0] h;
    m = 7'(hhmm[7:4]) * 7'd10 + 7'(hhmm[3:0]) + 7'(SNOOZE_MIN);
    h = 5'(hhmm[15:12]) * 5'd10 + 5'(hhmm[11:8]);
    if (m >= 7'd60) begin
      m = m - 7'd60;
      h = h + 5'd1;
    end
    if (h >= 5'd24) h = 5'd0;
    return {4'(h / 5'd10), 4'(h % 5'd10), 4'(m / 7'd10), 4'(m % 7'd10)};
  endfunction
`else
  logic unused_snooze;
  assign unused_snooze = key_snooze_i;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tone_d  = tone_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
`ifdef ALARM_BANK_SNOOZE_EN
    tgt_d   = tgt_q;
`endif
    case (state_q)
      IDLE: begin
        if (match) begin
          state_d = RINGING;
          idx_d   = hit_idx;
          tone_d  = hit_tone;
          cnt_d   = 8'd0;
          start_d = 1'b1;
        end
      end
      RINGING: begin
        // Dismiss beats timeout beats snooze; other slots are ignored here.
        if (key_dismiss_i) begin
          state_d = IDLE;
        end else if (sec_tick_i && (cnt_q + 8'd1 == RING_LIM)) begin
          state_d = IDLE;
`ifdef ALARM_BANK_SNOOZE_EN
        end else if (key_snooze_i) begin
          state_d = SNOOZED;
          tgt_d   = add_snooze(clock_data_i[23:8]);
`endif
        end else if (sec_tick_i) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef ALARM_BANK_SNOOZE_EN
      SNOOZED: begin
        if (key_dismiss_i) begin
          state_d = IDLE;
        end else if (match) begin
          state_d = RINGING;
          idx_d   = hit_idx;
          tone_d  = hit_tone;
          cnt_d   = 8'd0;
          start_d = 1'b1;
        end else if (sec_tick_i && (clock_data_i == {tgt_q, 8'h00})) begin
          state_d = RINGING;
          cnt_d   = 8'd0;
          start_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tone_q  <= '0;
      cnt_q   <= 8'd0;
      start_q <= 1'b0;
`ifdef ALARM_BANK_SNOOZE_EN
      tgt_q   <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tone_q  <= tone_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
`ifdef ALARM_BANK_SNOOZE_EN
      tgt_q   <= tgt_d;
`endif
    end
  end

  // Match above reads slot_q before this edge, so a same-cycle write is seen next cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N_ALARM; i++) slot_q[i] <= '0;
      wr_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (wr_en_i && wr_ok) slot_q[wr_idx_i] <= wr_data_i;
      wr_err_q  <= wr_en_i && !wr_ok;
      rd_data_q <= ({1'b0, rd_idx_i} < N_LIM) ? slot_q[rd_idx_i] : '0;
    end
  end

  assign wr_err_o      = wr_err_q;
  assign rd_data_o     = rd_data_q;
  assign ring_active_o = (state_q == RINGING);
  assign ring_start_o  = start_q;
  assign ring_tone_o   = (state_q == RINGING) ? tone_q : '0;
  assign ring_idx_o    = idx_q;

endmodule

// File: tb/tb_alarm_bank.sv
// tb/tb_alarm_bank.sv - directed scoreboard bench for alarm_bank
module tb_alarm_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sec_tick = 1'b0;
  logic [23:0] clock_data = 24'h0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_idx = 2'd0;
  logic [17:0] wr_data = 18'h0;
  logic        wr_err;
  logic [1:0]  rd_idx = 2'd0;
  logic [17:0] rd_data;
  logic        key_dismiss = 1'b0;
  logic        key_snooze = 1'b0;
  logic        ring_active, ring_start;
  logic [1:0]  ring_tone, ring_idx;

  logic        wr_en5 = 1'b0;
  logic [2:0]  wr_idx5 = 3'd0;
  logic [2:0]  rd_idx5 = 3'd0;
  logic        wr_err5, ring_active5, ring_start5;
  logic [17:0] rd_data5;
  logic [1:0]  ring_tone5;
  logic [2:0]  ring_idx5;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  alarm_bank u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .sec_tick_i(sec_tick), .clock_data_i(clock_data),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data), .wr_err_o(wr_err),
    .rd_idx_i(rd_idx), .rd_data_o(rd_data),
    .key_dismiss_i(key_dismiss), .key_snooze_i(key_snooze),
    .ring_active_o(ring_active), .ring_start_o(ring_start),
    .ring_tone_o(ring_tone), .ring_idx_o(ring_idx)
  );

  alarm_bank #(.N_ALARM(5)) u_dut5 (
    .clk_i(clk), .rst_n_i(rst_n), .sec_tick_i(1'b0), .clock_data_i(clock_data),
    .wr_en_i(wr_en5), .wr_idx_i(wr_idx5), .wr_data_i(wr_data), .wr_err_o(wr_err5),
    .rd_idx_i(rd_idx5), .rd_data_o(rd_data5),
    .key_dismiss_i(1'b0), .key_snooze_i(1'b0),
    .ring_active_o(ring_active5), .ring_start_o(ring_start5),
    .ring_tone_o(ring_tone5), .ring_idx_o(ring_idx5)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_cmp(input logic [31:0] obs);
    sb_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // {ring_start, ring_active, ring_tone}
  function automatic logic [31:0] rv();
    return {28'd0, ring_start, ring_active, ring_tone};
  endfunction

  task automatic wr(input logic [1:0] idx, input logic [17:0] data);
    wr_en = 1'b1;
    wr_idx = idx;
    wr_data = data;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wr5(input logic [2:0] idx);
    wr_en5 = 1'b1;
    wr_idx5 = idx;
    wr_data = {2'd1, 16'h0100};
    cyc();
    wr_en5 = 1'b0;
  endtask

  task automatic tick(input logic [23:0] t);
    clock_data = t;
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
  endtask

  task automatic dismiss();
    key_dismiss = 1'b1;
    cyc();
    key_dismiss = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    sb_push("rst_ring", 32'h0);    sb_cmp(rv());
    sb_push("rst_idx", 32'h0);     sb_cmp(32'(ring_idx));
    sb_push("rst_wr_err", 32'h0);  sb_cmp(32'(wr_err));
    sb_push("rst_rd", 32'h0);      sb_cmp(32'(rd_data));
    rst_n = 1'b1;
    cyc();

    // Basic write, readback and ring with timeout
    sb_push("wr_ok_err", 32'h0);
    wr(2'd2, {2'd1, 16'h0730});
    sb_cmp(32'(wr_err));
    rd_idx = 2'd2;
    sb_push("rd_slot2", 32'({2'd1, 16'h0730}));
    cyc();
    sb_cmp(32'(rd_data));
    sb_push("pre_match", 32'h0);
    tick(24'h072959);
    sb_cmp(rv());
    sb_push("ring_start", 32'b1101);
    tick(24'h073000);
    sb_cmp(rv());
    sb_push("ring_idx2", 32'd2);
    sb_cmp(32'(ring_idx));
    sb_push("start_once", 32'b0101);
    cyc();
    sb_cmp(rv());
`ifndef ALARM_BANK_SNOOZE_EN
    key_snooze = 1'b1;
    cyc();
    key_snooze = 1'b0;
    sb_push("snooze_ignored", 32'b0101);
    sb_cmp(rv());
`endif
    repeat (59) tick(24'h073001);
    sb_push("ring_59", 32'b0101);
    sb_cmp(rv());
    sb_push("ring_60", 32'b0000);
    tick(24'h073002);
    sb_cmp(rv());

    // Rejected writes and boundary acceptance
    rd_idx = 2'd0;
    sb_push("err_hh24", 32'd1);
    wr(2'd0, {2'd1, 16'h2400});
    sb_cmp(32'(wr_err));
    sb_push("err_pulse", 32'd0);
    cyc();
    sb_cmp(32'(wr_err));
    sb_push("rd_slot0_unch", 32'h0);
    sb_cmp(32'(rd_data));
    sb_push("err_mm60", 32'd1);
    wr(2'd0, {2'd1, 16'h1260});
    sb_cmp(32'(wr_err));
    sb_push("err_nibble", 32'd1);
    wr(2'd0, {2'd1, 16'h0A00});
    sb_cmp(32'(wr_err));
    sb_push("ok_2359", 32'd0);
    wr(2'd0, {2'd0, 16'h2359});
    sb_cmp(32'(wr_err));
    sb_push("rd_2359", 32'({2'd0, 16'h2359}));
    cyc();
    sb_cmp(32'(rd_data));
    sb_push("err_idx5", 32'd1);
    wr5(3'd5);
    sb_cmp(32'(wr_err5));
    sb_push("ok_idx4", 32'd0);
    wr5(3'd4);
    sb_cmp(32'(wr_err5));

    // Lowest index wins; edits to ringing slot do not stop it
    wr(2'd1, {2'd2, 16'h1200});
    wr(2'd3, {2'd3, 16'h1200});
    sb_push("prio_ring", 32'b1110);
    tick(24'h120000);
    sb_cmp(rv());
    sb_push("prio_idx", 32'd1);
    sb_cmp(32'(ring_idx));
    sb_push("edit_keeps", 32'b0110);
    wr(2'd1, {2'd0, 16'h1200});
    sb_cmp(rv());
    sb_push("dismiss", 32'b0000);
    dismiss();
    sb_cmp(rv());

    // Dismiss and snooze together: dismiss wins, no re-ring
    wr(2'd0, {2'd1, 16'h2358});
    sb_push("ring2358", 32'b1101);
    tick(24'h235800);
    sb_cmp(rv());
    sb_push("idx0", 32'd0);
    sb_cmp(32'(ring_idx));
    clock_data = 24'h235810;
    key_dismiss = 1'b1;
    key_snooze = 1'b1;
    cyc();
    key_dismiss = 1'b0;
    key_snooze = 1'b0;
    sb_push("dismiss_wins", 32'b0000);
    sb_cmp(rv());
    sb_push("no_rering", 32'b0000);
    tick(24'h000300);
    sb_cmp(rv());

    // Snooze across midnight (23:58 + 5 min = 00:03)
    sb_push("ring2358b", 32'b1101);
    tick(24'h235800);
    sb_cmp(rv());
    tick(24'h235809);
    clock_data = 24'h235810;
    key_snooze = 1'b1;
    cyc();
    key_snooze = 1'b0;
`ifdef ALARM_BANK_SNOOZE_EN
    sb_push("snoozed", 32'b0000);
    sb_cmp(rv());
    sb_push("pre_target", 32'b0000);
    tick(24'h000259);
    sb_cmp(rv());
    sb_push("snooze_rering", 32'b1101);
    tick(24'h000300);
    sb_cmp(rv());
`else
    sb_push("no_snooze_state", 32'b0101);
    sb_cmp(rv());
    sb_push("still_ringing", 32'b0101);
    tick(24'h000259);
    sb_cmp(rv());
    sb_push("no_restart", 32'b0101);
    tick(24'h000300);
    sb_cmp(rv());
`endif
    dismiss();

    // Write to matching slot in same cycle: old contents used
    wr_en = 1'b1;
    wr_idx = 2'd3;
    wr_data = {2'd0, 16'h1200};
    clock_data = 24'h120000;
    sec_tick = 1'b1;
    cyc();
    wr_en = 1'b0;
    sec_tick = 1'b0;
    sb_push("wr_same_cycle", 32'b1111);
    sb_cmp(rv());
    sb_push("wr_same_idx", 32'd3);
    sb_cmp(32'(ring_idx));
    dismiss();
    sb_push("new_val_applies", 32'b0000);
    tick(24'h120000);
    sb_cmp(rv());

    // Asynchronous reset mid-ring
    sb_push("ring_before_rst", 32'b1101);
    tick(24'h073000);
    sb_cmp(rv());
    #2;
    rst_n = 1'b0;
    #1;
    sb_push("async_rst", 32'b0000);
    sb_cmp(rv());
    cyc();
    rst_n = 1'b1;
    rd_idx = 2'd2;
    cyc();
    sb_push("slot2_cleared", 32'h0);
    sb_cmp(32'(rd_data));
    sb_push("no_ring_after_rst", 32'b0000);
    tick(24'h073000);
    sb_cmp(rv());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
